// File: rtl/bp_fe_fetch_sequencer.sv
// Front-end fetch sequencer: issues I$ fetch PCs, tracks in-flight fetch PCs for the
// realigner, and squashes/restarts fetch on a backend redirect.

module bp_fe_fetch_sequencer #(
    parameter int               vaddr_width_p  = 39,
    parameter int               fetch_cinstr_p = 4,
    parameter int               inflight_max_p = 2,
    parameter logic [63:0]      reset_pc_p     = 64'h0000_0000_8000_0000,
    localparam int              ptr_w          = $clog2(fetch_cinstr_p) + 1,
    localparam int              cnt_w          = $clog2(inflight_max_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    input  logic [ptr_w-1:0]         redirect_count_i,
    output logic                     fetch_v_o,
    output logic [vaddr_width_p-1:0] fetch_pc_o,
    input  logic                     fetch_ready_i,
    input  logic                     icache_data_v_i,
    output logic [vaddr_width_p-1:0] if2_pc_o,
    input  logic                     icache_yumi_i,
    output logic                     squash_o,
    input  logic                     stall_i,
    output logic [cnt_w-1:0]         inflight_o
);

    localparam int idx_w   = (inflight_max_p > 1) ? $clog2(inflight_max_p) : 1;
    localparam int blk_lsb = $clog2(2 * fetch_cinstr_p);

    typedef enum logic [1:0] {
        e_reset    = 2'd0,
        e_run      = 2'd1,
        e_redirect = 2'd2
    } state_e;

    state_e                   state_r;
    state_e                   state_next_s;
    logic [vaddr_width_p-1:0] pc_r;
    logic [vaddr_width_p-1:0] pc_next_s;
    logic [vaddr_width_p-1:0] fifo_r [inflight_max_p];
    logic [idx_w-1:0]         rd_ptr_r;
    logic [idx_w-1:0]         wr_ptr_r;
    logic [cnt_w-1:0]         count_r;
    logic                     redirect_s;
    logic                     fetch_v_s;
    logic                     push_s;
    logic                     pop_s;

    function automatic logic [idx_w-1:0] ptr_inc(input logic [idx_w-1:0] ptr);
        logic [idx_w-1:0] nxt;
        if (ptr == idx_w'(inflight_max_p - 1)) begin
            nxt = {idx_w{1'b0}};
        end else begin
            nxt = ptr + idx_w'(1);
        end
        return nxt;
    endfunction

    // Sequential fetch always continues at the start of the next fetch block.
    function automatic logic [vaddr_width_p-1:0] next_block(input logic [vaddr_width_p-1:0] pc);
        return {pc[vaddr_width_p-1:blk_lsb], {blk_lsb{1'b0}}}
             + vaddr_width_p'(2 * fetch_cinstr_p);
    endfunction

    // Issue qualification and FIFO handshakes
    always_comb begin
        redirect_s = redirect_v_i & (state_r != e_reset);
        fetch_v_s  = (state_r == e_run) & ~stall_i & ~redirect_v_i
                   & (count_r < cnt_w'(inflight_max_p));
        push_s     = fetch_v_s & fetch_ready_i;
        pop_s      = icache_yumi_i & (count_r != cnt_w'(0));
    end

    // Next-state and next-PC selection; redirect outranks everything
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            e_reset: begin
                state_next_s = e_run;
            end
            e_run: begin
                if (redirect_s) begin
                    state_next_s = e_redirect;
                end else begin
                    state_next_s = e_run;
                end
            end
            e_redirect: begin
                if (redirect_s) begin
                    state_next_s = e_redirect;
                end else begin
                    state_next_s = e_run;
                end
            end
            default: begin
                state_next_s = e_reset;
            end
        endcase
        // Restart past the parcels the realigner already holds.
        if (redirect_s) begin
            pc_next_s = redirect_pc_i
                      + ({{(vaddr_width_p-ptr_w){1'b0}}, redirect_count_i} << 1);
        end else if (push_s) begin
            pc_next_s = next_block(pc_r);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // State, fetch PC and in-flight PC FIFO registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= e_reset;
            pc_r     <= reset_pc_p[vaddr_width_p-1:0];
            rd_ptr_r <= {idx_w{1'b0}};
            wr_ptr_r <= {idx_w{1'b0}};
            count_r  <= {cnt_w{1'b0}};
            for (int i = 0; i < inflight_max_p; i++) begin
                fifo_r[i] <= {vaddr_width_p{1'b0}};
            end
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (redirect_s) begin
                rd_ptr_r <= {idx_w{1'b0}};
                wr_ptr_r <= {idx_w{1'b0}};
                count_r  <= {cnt_w{1'b0}};
            end else begin
                if (push_s) begin
                    fifo_r[wr_ptr_r] <= pc_r;
                    wr_ptr_r         <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + cnt_w'(1);
                    2'b01:   count_r <= count_r - cnt_w'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Output drive
    always_comb begin
        fetch_v_o  = fetch_v_s;
        fetch_pc_o = pc_r;
        squash_o   = redirect_s;
        inflight_o = count_r;
        if (count_r != cnt_w'(0)) begin
            if2_pc_o = fifo_r[rd_ptr_r];
        end else begin
            if2_pc_o = {vaddr_width_p{1'b0}};
        end
    end

    bp_fe_fetch_sequencer_checker #(
        .inflight_max_p (inflight_max_p),
        .cnt_w          (cnt_w)
    ) checker_inst (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .push            (push_s),
        .yumi            (icache_yumi_i),
        .redirect        (redirect_s),
        .icache_data_v_i (icache_data_v_i),
        .count           (count_r)
    );

endmodule

// Protocol checks on the in-flight FIFO and the I$ return path.
module bp_fe_fetch_sequencer_checker #(
    parameter int inflight_max_p = 2,
    parameter int cnt_w          = 2
) (
    input logic             clk_i,
    input logic             reset_i,
    input logic             push,
    input logic             yumi,
    input logic             redirect,
    input logic             icache_data_v_i,
    input logic [cnt_w-1:0] count
);

    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && (count == cnt_w'(inflight_max_p))));

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi && !redirect && (count == cnt_w'(0))));

    a_no_data_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(icache_data_v_i && (count == cnt_w'(0))));

endmodule

// File: tb/tb_bp_fe_fetch_sequencer.sv
// Scoreboard bench for bp_fe_fetch_sequencer: a queue-based reference model predicts
// each cycle's status and each fetch request; a monitor compares against the DUT.

module tb_bp_fe_fetch_sequencer;

    localparam int V = 39;
    localparam logic [V-1:0] RESET_PC = 39'h00_8000_0000;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         redirect_v_i = 1'b0;
    logic [V-1:0] redirect_pc_i = '0;
    logic [2:0]   redirect_count_i = '0;
    logic         fetch_v_o;
    logic [V-1:0] fetch_pc_o;
    logic         fetch_ready_i = 1'b0;
    logic         icache_data_v_i = 1'b0;
    logic [V-1:0] if2_pc_o;
    logic         icache_yumi_i = 1'b0;
    logic         squash_o;
    logic         stall_i = 1'b0;
    logic [1:0]   inflight_o;

    bp_fe_fetch_sequencer dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .redirect_v_i     (redirect_v_i),
        .redirect_pc_i    (redirect_pc_i),
        .redirect_count_i (redirect_count_i),
        .fetch_v_o        (fetch_v_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_ready_i    (fetch_ready_i),
        .icache_data_v_i  (icache_data_v_i),
        .if2_pc_o         (if2_pc_o),
        .icache_yumi_i    (icache_yumi_i),
        .squash_o         (squash_o),
        .stall_i          (stall_i),
        .inflight_o       (inflight_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         squash;
        logic [V-1:0] if2;
        int           inflight;
    } status_t;

    status_t      exp_status_q[$];
    logic [V-1:0] exp_fetch_q[$];
    int           tests = 0;
    int           fails = 0;

    // Reference model: next fetch PC, PCs in flight (oldest first), issue-blocking flags.
    logic [V-1:0] m_pc = RESET_PC;
    logic [V-1:0] m_q[$];
    bit           m_in_reset = 1'b1;
    bit           m_bubble = 1'b1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cycle(input bit rst, input bit stall, input bit ready, input bit yumi,
                         input bit redir, input logic [V-1:0] rpc, input int rcnt);
        status_t st;
        bit y;
        bit eff_redir;
        bit exp_v;
        @(negedge clk);
        y                = yumi && (m_q.size() > 0) && !rst;
        reset_i          = rst;
        stall_i          = stall;
        fetch_ready_i    = ready;
        icache_yumi_i    = y;
        icache_data_v_i  = y;
        redirect_v_i     = redir;
        redirect_pc_i    = rpc;
        redirect_count_i = 3'(rcnt);
        if (rst) begin
            st.squash = 1'b0; st.if2 = '0; st.inflight = 0;
            exp_status_q.push_back(st);
            m_q.delete();
            m_pc       = RESET_PC;
            m_in_reset = 1'b1;
            m_bubble   = 1'b1;
            return;
        end
        eff_redir   = redir && !m_in_reset;
        exp_v       = !m_bubble && !stall && !redir && (m_q.size() < 2);
        st.squash   = eff_redir;
        st.if2      = (m_q.size() > 0) ? m_q[0] : '0;
        st.inflight = m_q.size();
        exp_status_q.push_back(st);
        if (exp_v) exp_fetch_q.push_back(m_pc);
        m_in_reset = 1'b0;
        m_bubble   = 1'b0;
        if (eff_redir) begin
            m_q.delete();
            m_pc     = rpc + V'(2 * rcnt);
            m_bubble = 1'b1;
        end else begin
            if (y) void'(m_q.pop_front());
            if (exp_v && ready) begin
                m_q.push_back(m_pc);
                m_pc = m_pc - (m_pc % 8) + V'(8);
            end
        end
    endtask

    task automatic run(input int n, input bit stall, input bit ready, input bit yumi);
        for (int i = 0; i < n; i++) cycle(1'b0, stall, ready, yumi, 1'b0, '0, 0);
    endtask

    // Monitor: compare per-cycle status, and each presented fetch request in order.
    initial begin
        status_t st;
        logic [V-1:0] pc;
        forever begin
            @(negedge clk);
            #2;
            if (exp_status_q.size() > 0) begin
                st = exp_status_q.pop_front();
                check("squash", 64'(squash_o), 64'(st.squash));
                check("if2_pc", 64'(if2_pc_o), 64'(st.if2));
                check("inflight", 64'(inflight_o), 64'(st.inflight));
                if (fetch_v_o) begin
                    if (exp_fetch_q.size() == 0) begin
                        check("fetch_unexpected", 64'(fetch_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        pc = exp_fetch_q.pop_front();
                        check("fetch_pc", 64'(fetch_pc_o), 64'(pc));
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] r;
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0);
        // Fill to two in flight from reset, then retire one.
        run(5, 1'b0, 1'b1, 1'b0);
        run(1, 1'b0, 1'b1, 1'b1);
        run(2, 1'b0, 1'b1, 1'b0);
        // Redirect with two in flight, parcel count 0.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 39'h00_8000_1006, 0);
        run(4, 1'b0, 1'b1, 1'b0);
        // Redirect skipping three restored parcels.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 39'h00_8000_2002, 3);
        run(3, 1'b0, 1'b1, 1'b0);
        // Redirect together with ready and yumi.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 39'h00_8000_3000, 0);
        run(1, 1'b0, 1'b1, 1'b1);
        // Back-to-back redirects, then top-of-address-space wrap with stall.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 39'h00_1234_5670, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 39'h7F_FFFF_FFF8, 0);
        run(2, 1'b0, 1'b1, 1'b1);
        run(3, 1'b1, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1, 1'b1);
        // Reset in the middle of traffic, with a redirect held during reset release.
        run(2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 39'h00_4000_0000, 2);
        run(4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom()};
            cycle(1'b0, ($urandom_range(3) == 0), ($urandom_range(9) < 7),
                  ($urandom_range(1) == 1), ($urandom_range(19) == 0),
                  r[V-1:0], int'($urandom_range(4)));
        end
        run(4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #5;
        check("fetch_queue_drained", 64'(exp_fetch_q.size()), 64'd0);
        check("status_queue_drained", 64'(exp_status_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
